pi1_arb2: RTL and testbench

- Two-master, one-slave PerInt arbiter.
- Shares a single PerInt slave (boot ROM, RAM, or any PerInt peripheral) between two masters, e.g. CPU instruction fetch and a DMA/loader engine.
- Forwards the granted master's op/addr/data/sel to the slave and returns slave rdy to that master only.
- Arbitration is round-robin with a registered grant.

---
 rtl/pi1_arb2.sv | 142 ++++++++++++++
 tb/tb_pi1_arb2.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pi1_arb2.sv
// Two-master round-robin PerInt arbiter with a registered grant in front of one slave.
// Define PIARB2_BURSTLIMIT_EN to force a rotation after BURSTMAX accepted ops when the other master waits.
module pi1_arb2 #(
    parameter int ARCHBITSZ = 16,
    parameter int BURSTMAX  = 8,
    localparam int SELBITSZ  = ARCHBITSZ / 8,
    localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [1:0]           m0_op_i,
    input  logic [ADDRBITSZ-1:0] m0_addr_i,
    input  logic [ARCHBITSZ-1:0] m0_data_i,
    output logic [ARCHBITSZ-1:0] m0_data_o,
    input  logic [SELBITSZ-1:0]  m0_sel_i,
    output logic                 m0_rdy_o,
    output logic [ADDRBITSZ-1:0] m0_mapsz_o,
    input  logic [1:0]           m1_op_i,
    input  logic [ADDRBITSZ-1:0] m1_addr_i,
    input  logic [ARCHBITSZ-1:0] m1_data_i,
    output logic [ARCHBITSZ-1:0] m1_data_o,
    input  logic [SELBITSZ-1:0]  m1_sel_i,
    output logic                 m1_rdy_o,
    output logic [ADDRBITSZ-1:0] m1_mapsz_o,
    output logic [1:0]           s_op_o,
    output logic [ADDRBITSZ-1:0] s_addr_o,
    output logic [ARCHBITSZ-1:0] s_data_o,
    output logic [SELBITSZ-1:0]  s_sel_o,
    input  logic [ARCHBITSZ-1:0] s_data_i,
    input  logic                 s_rdy_i,
    input  logic [ADDRBITSZ-1:0] s_mapsz_i,
    output logic [1:0]           dbg_state_o
);

    // Handshake: an op is accepted on a rising edge where the granted master drives
    // op != NOOP and s_rdy_i is high; the granted master sees s_rdy_i as its rdy.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    if (BURSTMAX < 1 || BURSTMAX > 255) begin : g_bad_burstmax
        $error("pi1_arb2: BURSTMAX must be in 1..255");
    end

    state_t state;
    logic   last_served;
    logic   m0_req, m1_req, cur_req, oth_req;
    state_t oth_state;

    assign m0_req    = (m0_op_i != 2'b00);
    assign m1_req    = (m1_op_i != 2'b00);
    assign cur_req   = (state == G0) ? m0_req : m1_req;
    assign oth_req   = (state == G0) ? m1_req : m0_req;
    assign oth_state = (state == G0) ? G1 : G0;

    assign m0_data_o   = s_data_i;
    assign m1_data_o   = s_data_i;
    assign m0_mapsz_o  = s_mapsz_i;
    assign m1_mapsz_o  = s_mapsz_i;
    assign dbg_state_o = state;

    // Slave-side mux follows the registered grant, so reset drops it without a clock edge.
    always_comb begin
        s_op_o   = 2'b00;
        s_addr_o = '0;
        s_data_o = '0;
        s_sel_o  = '0;
        m0_rdy_o = 1'b0;
        m1_rdy_o = 1'b0;
        case (state)
            G0: begin
                s_op_o   = m0_op_i;
                s_addr_o = m0_addr_i;
                s_data_o = m0_data_i;
                s_sel_o  = m0_sel_i;
                m0_rdy_o = s_rdy_i;
            end
            G1: begin
                s_op_o   = m1_op_i;
                s_addr_o = m1_addr_i;
                s_data_o = m1_data_i;
                s_sel_o  = m1_sel_i;
                m1_rdy_o = s_rdy_i;
            end
            default: ;
        endcase
    end

`ifdef PIARB2_BURSTLIMIT_EN
    logic [7:0] burst_cnt;
    logic [8:0] burst_inc;
    logic       burst_hit;

    assign burst_inc = {1'b0, burst_cnt} + 9'd1;
    assign burst_hit = (burst_inc >= 9'(BURSTMAX));
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            last_served <= 1'b1;
`ifdef PIARB2_BURSTLIMIT_EN
            burst_cnt   <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef PIARB2_BURSTLIMIT_EN
                    burst_cnt <= 8'd0;
`endif
                    if (m0_req && (!m1_req || last_served)) state <= G0;
                    else if (m1_req)                        state <= G1;
                end
                G0, G1: begin
                    if (s_rdy_i) begin
                        // A NOOP edge is the only normal way out, so a pending read completes first.
                        if (!cur_req) begin
                            last_served <= (state == G1);
                            state       <= oth_req ? oth_state : IDLE;
`ifdef PIARB2_BURSTLIMIT_EN
                            burst_cnt   <= 8'd0;
`endif
                        end
`ifdef PIARB2_BURSTLIMIT_EN
                        else if (burst_hit && oth_req) begin
                            last_served <= (state == G1);
                            state       <= oth_state;
                            burst_cnt   <= 8'd0;
                        end else begin
                            burst_cnt <= burst_hit ? 8'(BURSTMAX) : burst_inc[7:0];
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pi1_arb2.sv
// Randomized and directed bench for pi1_arb2 against a transaction-level grant model.
module tb_pi1_arb2;

    localparam int ARCHBITSZ = 16;
    localparam int BURSTMAX  = 4;
    localparam int AW        = 15;
    localparam int SW        = 2;
`ifdef PIARB2_BURSTLIMIT_EN
    localparam int EXP_BURST = BURSTMAX;
`else
    localparam int EXP_BURST = 10;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           op_v   [2];
    logic [AW-1:0]        addr_v [2];
    logic [ARCHBITSZ-1:0] data_v [2];
    logic [SW-1:0]        sel_v  [2];
    logic [ARCHBITSZ-1:0] m0_data_o, m1_data_o, s_data_o, s_data;
    logic                 m0_rdy_o, m1_rdy_o, s_rdy;
    logic [AW-1:0]        m0_mapsz_o, m1_mapsz_o, s_addr_o, s_mapsz;
    logic [1:0]           s_op_o, dbg_state;
    logic [SW-1:0]        s_sel_o;

    int n_checks = 0;
    int n_fail   = 0;

    // master driver state
    int         rem  [2];
    logic [1:0] kind [2];
    bit         seen [2];

    // grant model and read-data scoreboard
    int                   owner;
    int                   last;
    int                   burst;
    logic [ARCHBITSZ-1:0] exp_q[$];
    int                   who_q[$];

    always #5 clk = ~clk;

    pi1_arb2 #(.ARCHBITSZ(ARCHBITSZ), .BURSTMAX(BURSTMAX)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_op_i(op_v[0]), .m0_addr_i(addr_v[0]), .m0_data_i(data_v[0]), .m0_data_o(m0_data_o),
        .m0_sel_i(sel_v[0]), .m0_rdy_o(m0_rdy_o), .m0_mapsz_o(m0_mapsz_o),
        .m1_op_i(op_v[1]), .m1_addr_i(addr_v[1]), .m1_data_i(data_v[1]), .m1_data_o(m1_data_o),
        .m1_sel_i(sel_v[1]), .m1_rdy_o(m1_rdy_o), .m1_mapsz_o(m1_mapsz_o),
        .s_op_o(s_op_o), .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o),
        .s_data_i(s_data), .s_rdy_i(s_rdy), .s_mapsz_i(s_mapsz),
        .dbg_state_o(dbg_state)
    );

    function automatic logic [ARCHBITSZ-1:0] rom(input logic [AW-1:0] a);
        if (a == 15'd3) return 16'hBEEF;
        return (16'(a) * 16'h0107) ^ 16'h5A5A;
    endfunction

    // ROM-like slave: read data appears the cycle after acceptance.
    always @(posedge clk) begin
        if (s_op_o[1] && s_rdy) s_data <= rom(s_addr_o);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic req(input int i, input logic [1:0] k, input int n, input logic [AW-1:0] a);
        rem[i]    = n;
        kind[i]   = k;
        addr_v[i] = a;
        data_v[i] = 16'($urandom);
        sel_v[i]  = 2'($urandom_range(1, 3));
    endtask

    // Called at a falling edge: a master drops or renews its op only after seeing rdy.
    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            if (seen[i]) begin
                rem[i]--;
                seen[i] = 1'b0;
                if (rem[i] > 0) begin
                    addr_v[i] = 15'($urandom);
                    data_v[i] = 16'($urandom);
                    sel_v[i]  = 2'($urandom_range(1, 3));
                end
            end
            op_v[i] = (rem[i] > 0) ? kind[i] : 2'b00;
        end
        s_mapsz = 15'($urandom);
    endtask

    task automatic step();
        logic [1:0]           eop;
        logic [AW-1:0]        eaddr;
        logic [ARCHBITSZ-1:0] edata;
        logic [SW-1:0]        esel;
        logic                 erdy [2];
        int                   x, y, w;
        #2;
        eop = 2'b00; eaddr = '0; edata = '0; esel = '0;
        erdy[0] = 1'b0; erdy[1] = 1'b0;
        if (owner >= 0) begin
            eop = op_v[owner]; eaddr = addr_v[owner]; edata = data_v[owner]; esel = sel_v[owner];
            erdy[owner] = s_rdy;
        end
        check("s_op", 32'(s_op_o), 32'(eop));
        check("s_addr", 32'(s_addr_o), 32'(eaddr));
        check("s_data", 32'(s_data_o), 32'(edata));
        check("s_sel", 32'(s_sel_o), 32'(esel));
        check("m0_rdy", 32'(m0_rdy_o), 32'(erdy[0]));
        check("m1_rdy", 32'(m1_rdy_o), 32'(erdy[1]));
        check("m0_mapsz", 32'(m0_mapsz_o), 32'(s_mapsz));
        check("m1_mapsz", 32'(m1_mapsz_o), 32'(s_mapsz));
        seen[0] = m0_rdy_o && (op_v[0] != 2'b00);
        seen[1] = m1_rdy_o && (op_v[1] != 2'b00);
        if (owner < 0) begin
            if (op_v[0] != 2'b00 && (op_v[1] == 2'b00 || last == 1)) owner = 0;
            else if (op_v[1] != 2'b00) owner = 1;
            burst = 0;
        end else if (s_rdy) begin
            x = owner;
            y = 1 - x;
            if (op_v[x] == 2'b00) begin
                last  = x;
                owner = (op_v[y] != 2'b00) ? y : -1;
                burst = 0;
            end else begin
                if (op_v[x][1]) begin
                    exp_q.push_back(rom(addr_v[x]));
                    who_q.push_back(x);
                end
                burst++;
`ifdef PIARB2_BURSTLIMIT_EN
                if (burst >= BURSTMAX && op_v[y] != 2'b00) begin
                    owner = y;
                    last  = x;
                    burst = 0;
                end
`endif
            end
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            w = who_q.pop_front();
            check(w == 1 ? "m1_rdata" : "m0_rdata", 32'(w == 1 ? m1_data_o : m0_data_o),
                  32'(exp_q.pop_front()));
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rem[i] = 0; seen[i] = 1'b0; op_v[i] = 2'b00;
        end
        owner = -1; last = 1; burst = 0;
        exp_q.delete();
        who_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic flush(input int n);
        repeat (n) begin
            drive();
            step();
        end
    endtask

    initial begin
        int nacc0;
        bit got1;
        rst = 1'b1;
        s_rdy = 1'b1;
        s_data = '0;
        s_mapsz = 15'h1234;
        for (int i = 0; i < 2; i++) begin
            op_v[i] = 2'b00; addr_v[i] = '0; data_v[i] = '0; sel_v[i] = '0; rem[i] = 0; seen[i] = 1'b0;
            kind[i] = 2'b00;
        end
        owner = -1; last = 1; burst = 0;
        @(negedge clk);
        #1;
        check("rst_s_op", 32'(s_op_o), 32'd0);
        check("rst_s_addr", 32'(s_addr_o), 32'd0);
        check("rst_m0_rdy", 32'(m0_rdy_o), 32'd0);
        check("rst_m1_rdy", 32'(m1_rdy_o), 32'd0);
        check("rst_mapsz", 32'(m1_mapsz_o), 32'h1234);

        // single read from the ROM at word 3
        do_reset();
        req(0, 2'b10, 1, 15'd3);
        drive(); #1;
        check("rom_c1_op", 32'(s_op_o), 32'd0);
        check("rom_c1_m1rdy", 32'(m1_rdy_o), 32'd0);
        step();
        drive(); #1;
        check("rom_c2_op", 32'(s_op_o), 32'd2);
        check("rom_c2_addr", 32'(s_addr_o), 32'd3);
        check("rom_c2_m0rdy", 32'(m0_rdy_o), 32'd1);
        check("rom_c2_m1rdy", 32'(m1_rdy_o), 32'd0);
        step();
        drive(); #1;
        check("rom_c3_data", 32'(m0_data_o), 32'hBEEF);
        check("rom_c3_m1rdy", 32'(m1_rdy_o), 32'd0);
        step();

        // simultaneous requests: m0 first, then m1, then m0 again
        do_reset();
        req(0, 2'b10, 1, 15'd5);
        req(1, 2'b10, 1, 15'd9);
        drive(); #1;
        check("tie_idle_op", 32'(s_op_o), 32'd0);
        step();
        drive(); #1;
        check("tie_first_m0rdy", 32'(m0_rdy_o), 32'd1);
        check("tie_first_addr", 32'(s_addr_o), 32'd5);
        step();
        drive(); #1;
        check("tie_noop_m1rdy", 32'(m1_rdy_o), 32'd0);
        step();
        drive(); #1;
        check("tie_second_m1rdy", 32'(m1_rdy_o), 32'd1);
        check("tie_second_addr", 32'(s_addr_o), 32'd9);
        step();
        flush(1);
        req(0, 2'b10, 1, 15'd5);
        req(1, 2'b10, 1, 15'd9);
        flush(1);
        drive(); #1;
        check("tie_again_m0rdy", 32'(m0_rdy_o), 32'd1);
        check("tie_again_addr", 32'(s_addr_o), 32'd5);
        step();
        flush(6);

        // slave stall while m1 holds the grant
        do_reset();
        req(1, 2'b10, 1, 15'd7);
        flush(1);
        s_rdy = 1'b0;
        req(0, 2'b01, 1, 15'd4);
        repeat (5) begin
            drive(); #1;
            check("stall_owner_addr", 32'(s_addr_o), 32'd7);
            check("stall_m0rdy", 32'(m0_rdy_o), 32'd0);
            step();
            check("stall_no_acc", 32'(seen[1]), 32'd0);
        end
        s_rdy = 1'b1;
        drive(); #1;
        check("stall_release_m1rdy", 32'(m1_rdy_o), 32'd1);
        step();
        check("stall_m1_acc", 32'(seen[1]), 32'd1);
        flush(6);

        // asynchronous reset in the middle of an m0 write
        do_reset();
        req(0, 2'b01, 1, 15'd11);
        flush(1);
        drive(); #1;
        check("rstmid_pre_op", 32'(s_op_o), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rstmid_op", 32'(s_op_o), 32'd0);
        check("rstmid_addr", 32'(s_addr_o), 32'd0);
        check("rstmid_m0rdy", 32'(m0_rdy_o), 32'd0);

        // streaming m0 against a waiting m1
        do_reset();
        req(0, 2'b10, 10, 15'd0);
        req(1, 2'b10, 1, 15'd1);
        nacc0 = 0;
        got1 = 1'b0;
        for (int c = 0; c < 40 && !got1; c++) begin
            drive();
            step();
            if (seen[1]) got1 = 1'b1;
            else if (seen[0]) nacc0++;
        end
        check("burst_m1_served", 32'(got1), 32'd1);
        check("burst_m0_count", 32'(nacc0), 32'(EXP_BURST));
        flush(14);

        // random traffic with random slave stalls
        do_reset();
        repeat (600) begin
            for (int i = 0; i < 2; i++) begin
                if (rem[i] == 0 && $urandom_range(0, 3) == 0)
                    req(i, 2'($urandom_range(1, 3)), int'($urandom_range(1, 6)), 15'($urandom));
            end
            s_rdy = ($urandom_range(0, 3) != 0);
            drive();
            step();
        end
        s_rdy = 1'b1;
        flush(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: bench did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
